// File: rtl/bp_me_network_pkt_serialize_resp_pkg.sv
// Shared types and sizing helpers for the ME network packet serialisers.
package bp_me_network_pkt_serialize_resp_pkg;

    // Serialiser control states; S_RESET keeps ready_o low until reset is released.
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_SEND  = 2'd2
    } serialize_state_e;

    // Ceiling division, used to size packets in whole flits.
    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of the wormhole routing header {len, y, x}.
    function automatic int unsigned wormhole_hdr_width(
        input int unsigned x_cord_width,
        input int unsigned y_cord_width,
        input int unsigned len_width
    );
        return x_cord_width + y_cord_width + len_width;
    endfunction

endpackage

// File: rtl/bp_me_wormhole_dst_map.sv
// Maps a CCE id onto wormhole x/y router coordinates (combinational).
module bp_me_wormhole_dst_map
    import bp_me_network_pkt_serialize_resp_pkg::*;
#(
    parameter int unsigned num_cce_p      = 1,
    parameter int unsigned x_cord_width_p = 4,
    parameter int unsigned y_cord_width_p = 2,
    parameter int unsigned x_stride_p     = 2,
    parameter int unsigned x_offset_p     = 0,
    parameter int unsigned y_cord_p       = 0
) (
    input  logic [safe_clog2(num_cce_p)-1:0] dst_id,
    output logic [x_cord_width_p-1:0]        x_cord,
    output logic [y_cord_width_p-1:0]        y_cord
);

    // x wraps modulo 2^x_cord_width_p; y is the same for every CCE.
    always_comb begin
        x_cord = x_cord_width_p'(int'(dst_id) * x_stride_p + x_offset_p);
        y_cord = y_cord_width_p'(y_cord_p);
    end

endmodule

// File: rtl/bp_me_network_pkt_serialize_resp.sv
// LCE->CCE response packet encoder: packs header, optional block data and
// wormhole routing fields, then streams the packet out as fixed-width flits.
module bp_me_network_pkt_serialize_resp
    import bp_me_network_pkt_serialize_resp_pkg::*;
#(
    parameter int unsigned num_cce_p       = 1,
    parameter int unsigned payload_width_p = 42,
    parameter int unsigned data_width_p    = 64,
    parameter int unsigned flit_width_p    = 32,
    parameter int unsigned x_cord_width_p  = 4,
    parameter int unsigned y_cord_width_p  = 2,
    parameter int unsigned len_width_p     = 3,
    parameter int unsigned x_stride_p      = 2,
    parameter int unsigned x_offset_p      = 0,
    parameter int unsigned y_cord_p        = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              v_i,
    output logic                              ready_o,
    input  logic [payload_width_p-1:0]        payload_i,
    input  logic [data_width_p-1:0]           data_i,
    input  logic                              has_data_i,
    input  logic [safe_clog2(num_cce_p)-1:0]  dst_id_i,
    output logic                              v_o,
    output logic [flit_width_p-1:0]           data_o,
    input  logic                              ready_i
);

    localparam int unsigned hdr_bits_lp    =
        wormhole_hdr_width(x_cord_width_p, y_cord_width_p, len_width_p) + payload_width_p;
    localparam int unsigned short_flits_lp = ceil_div(hdr_bits_lp, flit_width_p);
    localparam int unsigned long_flits_lp  = ceil_div(hdr_bits_lp + data_width_p, flit_width_p);
    localparam int unsigned pkt_bits_lp    = long_flits_lp * flit_width_p;

    localparam int unsigned y_lsb_lp       = x_cord_width_p;
    localparam int unsigned len_lsb_lp     = x_cord_width_p + y_cord_width_p;
    localparam int unsigned payload_lsb_lp = len_lsb_lp + len_width_p;
    localparam int unsigned data_lsb_lp    = hdr_bits_lp;

    localparam bit len_fits_lp = (long_flits_lp - 1) < (1 << len_width_p);

    logic [x_cord_width_p-1:0] dst_x;
    logic [y_cord_width_p-1:0] dst_y;
    logic [pkt_bits_lp-1:0]    pkt_next;
    logic [pkt_bits_lp-1:0]    pkt_r;
    logic [len_width_p-1:0]    len_next;
    logic [len_width_p-1:0]    count_r;
    logic [len_width_p-1:0]    last_idx_r;
    serialize_state_e          state_r;
    logic                      last_flit;
    logic                      accept;

    bp_me_wormhole_dst_map #(
        .num_cce_p      (num_cce_p),
        .x_cord_width_p (x_cord_width_p),
        .y_cord_width_p (y_cord_width_p),
        .x_stride_p     (x_stride_p),
        .x_offset_p     (x_offset_p),
        .y_cord_p       (y_cord_p)
    ) dst_map (
        .dst_id (dst_id_i),
        .x_cord (dst_x),
        .y_cord (dst_y)
    );

    // Assemble the full packet, LSB first: x, y, len, payload, data, zero pad.
    always_comb begin
        pkt_next = '0;
        len_next = has_data_i ? len_width_p'(long_flits_lp - 1)
                              : len_width_p'(short_flits_lp - 1);
        pkt_next[0 +: x_cord_width_p]               = dst_x;
        pkt_next[y_lsb_lp +: y_cord_width_p]        = dst_y;
        pkt_next[len_lsb_lp +: len_width_p]         = len_next;
        pkt_next[payload_lsb_lp +: payload_width_p] = payload_i;
        if (has_data_i) begin
            pkt_next[data_lsb_lp +: data_width_p] = data_i;
        end
    end

    // Handshake and flit selection; ready_o only reaches ready_i on the last flit.
    always_comb begin
        last_flit = (count_r == last_idx_r);
        v_o       = (state_r == S_SEND);
        ready_o   = (state_r == S_IDLE) | ((state_r == S_SEND) & ready_i & last_flit);
        accept    = v_i & ready_o;
        data_o    = pkt_r[count_r * flit_width_p +: flit_width_p];
    end

    // Serialiser FSM: load on accept, step the flit counter on each downstream handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= S_RESET;
            pkt_r      <= '0;
            count_r    <= '0;
            last_idx_r <= '0;
        end else begin
            case (state_r)
                S_RESET: begin
                    state_r <= S_IDLE;
                end
                S_IDLE: begin
                    if (accept) begin
                        pkt_r      <= pkt_next;
                        last_idx_r <= len_next;
                        count_r    <= '0;
                        state_r    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (ready_i) begin
                        if (!last_flit) begin
                            count_r <= count_r + len_width_p'(1);
                        end else if (accept) begin
                            // Next packet loads directly over the finished one: no idle bubble.
                            pkt_r      <= pkt_next;
                            last_idx_r <= len_next;
                            count_r    <= '0;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Length field must encode the long packet's last flit index.
    len_fits_a: assert property (@(posedge clk_i) len_fits_lp);

    // An accepted response must carry a fully known header payload.
    payload_known_a: assert property (@(posedge clk_i) disable iff (reset_i)
        (v_i && ready_o) |-> !$isunknown(payload_i));

endmodule

// File: tb/tb_bp_me_network_pkt_serialize_resp.sv
// Self-checking bench for the response packet serialiser.
module tb_bp_me_network_pkt_serialize_resp;

    localparam int unsigned HDR_BITS = 4 + 2 + 3 + 42;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic [41:0] payload_i;
    logic [63:0] data_i;
    logic        has_data_i;
    logic [1:0]  dst_id_i;
    logic        v_o;
    logic [31:0] data_o;
    logic        ready_i;

    logic        w_v_i;
    logic        w_ready_o;
    logic        w_v_o;
    logic [31:0] w_data_o;
    logic        w_ready_i;
    logic [1:0]  w_dst_id_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rmode    = 0;
    int rphase   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    bp_me_network_pkt_serialize_resp #(
        .num_cce_p (4)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .payload_i  (payload_i),
        .data_i     (data_i),
        .has_data_i (has_data_i),
        .dst_id_i   (dst_id_i),
        .v_o        (v_o),
        .data_o     (data_o),
        .ready_i    (ready_i)
    );

    bp_me_network_pkt_serialize_resp #(
        .num_cce_p      (4),
        .x_cord_width_p (2)
    ) dut_wrap (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .v_i        (w_v_i),
        .ready_o    (w_ready_o),
        .payload_i  (payload_i),
        .data_i     (data_i),
        .has_data_i (has_data_i),
        .dst_id_i   (w_dst_id_i),
        .v_o        (w_v_o),
        .data_o     (w_data_o),
        .ready_i    (w_ready_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Downstream ready pattern: always, 1,0,0 repeating, or random.
    always @(negedge clk_i) begin
        case (rmode)
            0:       ready_i = 1'b1;
            1:       begin ready_i = (rphase % 3 == 0); rphase++; end
            default: ready_i = ($urandom % 4) != 0;
        endcase
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Collect flits at handshake and check stability across stalls.
    always @(posedge clk_i) begin
        if (reset_i) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_v", v_o, 1);
                check("hold_data", data_o, prev_data);
            end
            if (v_o && ready_i) begin
                got_q.push_back(data_o);
                got_cyc.push_back(cyc);
            end
            prev_stall <= v_o && !ready_i;
            prev_data  <= data_o;
        end
    end

    // Reference: packet as an integer built from its fields, cut into 32-bit flits.
    function automatic void model_push(input logic [41:0] p, input logic [63:0] d,
                                       input logic hd, input logic [1:0] dst);
        int unsigned nbits = HDR_BITS + (hd ? 64 : 0);
        int unsigned nfl   = (nbits + 31) / 32;
        logic [127:0] pkt;
        pkt = 128'((int'(dst) * 2) % 16);
        pkt = pkt | (128'(nfl - 1) << 6);
        pkt = pkt | (128'(p) << 9);
        if (hd) pkt = pkt | (128'(d) << 51);
        for (int k = 0; k < int'(nfl); k++) exp_q.push_back(pkt[k*32 +: 32]);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [41:0] p, input logic [63:0] d, input logic hd,
                        input logic [1:0] dst, input bit keep, output int acc_cyc, output int waits);
        payload_i  = p;
        data_i     = d;
        has_data_i = hd;
        dst_id_i   = dst;
        v_i        = 1'b1;
        waits      = 0;
        acc_cyc    = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (ready_o) begin
                acc_cyc = cyc;
                model_push(p, d, hd, dst);
                @(negedge clk_i);
                if (!keep) v_i = 1'b0;
                return;
            end
            waits++;
            @(negedge clk_i);
        end
        check("accept_timeout", 0, 1);
        v_i = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            if (got_q.size() >= exp_q.size() && !v_o) begin
                done = 1;
                break;
            end
            @(negedge clk_i);
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic compare_clear();
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        check("flit_count", got_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) check("flit", got_q[i], exp_q[i]);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [41:0] payload;
        logic [63:0] data;
        logic        has_data;
        logic [1:0]  dst;
        int          exp_nflits;
        int          exp_len;
        int          exp_x;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int acc, acc2, w, w2;
        logic [31:0] f0;
        logic [127:0] r;

        vecs[0] = '{42'h2AB_CDEF_0123, 64'h0,                   1'b0, 2'd3, 2, 1, 6};
        vecs[1] = '{42'h155_5555_5555, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 2'd2, 4, 3, 4};
        vecs[2] = '{42'h3FF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd0, 4, 3, 0};
        vecs[3] = '{42'h001_2345_6789, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd1, 2, 1, 2};

        reset_i    = 1'b1;
        v_i        = 1'b0;
        payload_i  = '0;
        data_i     = '0;
        has_data_i = 1'b0;
        dst_id_i   = '0;
        w_v_i      = 1'b0;
        w_ready_i  = 1'b0;
        w_dst_id_i = 2'd3;

        repeat (3) @(negedge clk_i);
        check("rst_v_o", v_o, 0);
        check("rst_ready_o", ready_o, 0);
        check("rst_wrap_v_o", w_v_o, 0);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready_o", ready_o, 1);
        check("post_rst_v_o", v_o, 0);

        // Directed table, ready_i held high.
        rmode = 0;
        for (int t = 0; t < 4; t++) begin
            send(vecs[t].payload, vecs[t].data, vecs[t].has_data, vecs[t].dst, 0, acc, w);
            drain();
            check("n_flits", got_q.size(), vecs[t].exp_nflits);
            f0 = (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx;
            check("hdr_x", f0[3:0], vecs[t].exp_x);
            check("hdr_y", f0[5:4], 0);
            check("hdr_len", f0[8:6], vecs[t].exp_len);
            if (got_cyc.size() == vecs[t].exp_nflits) begin
                check("first_flit_cycle", got_cyc[0], acc + 1);
                check("last_flit_cycle", got_cyc[vecs[t].exp_nflits-1], acc + vecs[t].exp_nflits);
                if (vecs[t].has_data) begin
                    r = {got_q[3], got_q[2], got_q[1], got_q[0]};
                    check("data_reassembly", r[114:51], vecs[t].data);
                    check("long_pad", r[127:115], 0);
                end else begin
                    check("short_pad", got_q[1][31:19], 0);
                end
            end
            check("ready_after_pkt", ready_o, 1);
            compare_clear();
        end

        // Backpressure on a long packet.
        rmode = 1;
        rphase = 0;
        send(42'h0AA_5500_FF11, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd1, 0, acc, w);
        drain();
        compare_clear();
        rmode = 0;
        @(negedge clk_i);

        // Back-to-back long then short with v_i held high.
        send(42'h111_2222_3333, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 2'd3, 1, acc, w);
        send(42'h044_4444_4444, 64'h0, 1'b0, 2'd2, 0, acc2, w2);
        check("b2b_wait_cycles", w2, 3);
        check("b2b_accept_cycle", acc2, acc + 4);
        drain();
        check("b2b_flits", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_cyc.size(); i++) check("b2b_cycle", got_cyc[i], acc + 1 + i);
        compare_clear();

        // Reset mid-packet.
        send(42'h3C3_C3C3_C3C3, 64'h1111_2222_3333_4444, 1'b1, 2'd0, 0, acc, w);
        for (int i = 0; i < 50 && got_q.size() < 2; i++) @(negedge clk_i);
        check("mid_flits_before_rst", got_q.size(), 2);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("mid_rst_v_o", v_o, 0);
        check("mid_rst_ready_o", ready_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("mid_post_rst_ready_o", ready_o, 1);
        check("mid_post_rst_v_o", v_o, 0);
        for (int i = 0; i < 2 && i < got_q.size(); i++) check("mid_partial_flit", got_q[i], exp_q[i]);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        send(42'h2AB_CDEF_0123, 64'h0, 1'b0, 2'd3, 0, acc, w);
        drain();
        compare_clear();

        // Randomised traffic with random backpressure.
        rmode = 2;
        for (int n = 0; n < 30; n++) begin
            bit keep = (n != 29) && ($urandom % 2 == 1);
            send(42'({$urandom, $urandom}), {$urandom, $urandom}, 1'($urandom % 2),
                 2'($urandom % 4), keep, acc, w);
            if (!keep) repeat ($urandom % 3) @(negedge clk_i);
        end
        drain();
        compare_clear();
        rmode = 0;

        // Narrow x coordinate wraps: 3*2 mod 4 = 2.
        @(negedge clk_i);
        has_data_i = 1'b0;
        w_v_i = 1'b1;
        #1;
        check("wrap_ready_o", w_ready_o, 1);
        @(negedge clk_i);
        w_v_i = 1'b0;
        check("wrap_v_o", w_v_o, 1);
        check("wrap_x", w_data_o[1:0], 2);
        check("wrap_len", w_data_o[6:4], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
